make_bytes: RTL
===============

MAKE_BYTES -- requirements
Module: make_bytes

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning byte order: 1 = bits [31:24] first, 0 = bits [7:0] first.
REQ-002 SHALL have parameter COUNT_W, default 8, meaning width of the completed-word counter.
REQ-003 SHALL have port i_clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port i_word, input, 32, meaning the word to send.
REQ-006 SHALL have port i_valid, input, 1, meaning i_word is valid this cycle.
REQ-007 SHALL have port o_ready, output, 1, meaning the block can accept a word.
REQ-008 SHALL have port o_tx_data, output, 8, meaning the byte presented to the UART transmitter.
REQ-009 SHALL have port o_tx_start, output, 1, meaning a one-cycle pulse that starts a UART byte transmission.
REQ-010 SHALL have port i_tx_done, input, 1, meaning the UART transmitter has finished the current byte.
REQ-011 SHALL have port o_done, output, 1, meaning a one-cycle pulse when the full word has been sent.
REQ-012 SHALL have port o_word_count, output, COUNT_W, meaning the number of words completed, modulo 2^COUNT_W.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND, WAIT and FINISH.
REQ-014 In IDLE, o_ready=1 and all other states drive o_ready=0.
REQ-015 In IDLE with i_valid=1, the block SHALL latch i_word, clear the byte index to 0 and go to SEND; a word offered in any other state is ignored.
REQ-016 SEND SHALL last one cycle; during it o_tx_start=1 and o_tx_data=selected byte, then the FSM goes to WAIT.
REQ-017 o_tx_start SHALL be registered: if the word is accepted at edge N, the pulse is high in the cycle after edge N.
REQ-018 o_tx_data SHALL hold the selected byte stable from SEND until the matching i_tx_done.
REQ-019 In WAIT, i_tx_done=1 SHALL increment the byte index; if the index was 3, the FSM goes to FINISH, otherwise to SEND.
REQ-020 i_tx_done asserted in IDLE, SEND or FINISH SHALL be ignored.
REQ-021 Back-to-back bytes: i_tx_done seen at edge M SHALL give the next o_tx_start in the cycle after edge M.
REQ-022 FINISH SHALL last one cycle: o_done=1, o_word_count increments (wrapping from 2^COUNT_W-1 to 0), then the FSM goes to IDLE.
REQ-023 Minimum word period SHALL be 1 (accept) + 4×(1 SEND + ≥1 WAIT) + 1 FINISH cycles.
REQ-024 i_valid=1 during FINISH SHALL NOT be accepted; acceptance is possible in the following IDLE cycle.

Reset
REQ-025 i_reset=1 SHALL, asynchronously and at any state including mid-word, force: FSM to IDLE, o_ready=1, o_tx_start=0, o_done=0, o_tx_data=8'h00, o_word_count=0, byte index=0, latched word=0.
REQ-026 After reset is released, the first accepted word SHALL start from byte 0; a partial word interrupted by reset is never resumed.

Configuration
REQ-027 Macro MAKE_BYTES_HEADER_EN SHALL control an optional header byte.
REQ-028 With MAKE_BYTES_HEADER_EN defined, each word SHALL be preceded by header byte 8'hA5 using the same SEND/WAIT handshake: 5 bytes per word, FINISH after the 5th i_tx_done.
REQ-029 Without the macro, no header is sent: exactly 4 bytes per word, and no header logic is present.

Verification
REQ-030 The bench SHALL cover: reset, i_word=32'hDEADBEEF, MSB_FIRST=1, i_tx_done 3 cycles after each start -> o_tx_data sequence DE, AD, BE, EF, 4 start pulses, o_done once, o_word_count=1.
REQ-031 The bench SHALL cover: MSB_FIRST=0, i_word=32'h12345678 -> byte sequence 78, 56, 34, 12.
REQ-032 The bench SHALL cover: i_valid held high with a new word while busy, plus i_tx_done pulsed during SEND -> the second word is not latched, the byte index does not advance, and the sequence is unchanged.
REQ-033 The bench SHALL cover: COUNT_W=2, send 5 words -> o_word_count goes 1, 2, 3, 0, 1.
REQ-034 The bench SHALL cover: i_reset asserted after the 2nd byte's i_tx_done -> all outputs at reset values immediately; the next word 32'hCAFEF00D is sent as CA, FE, F0, 0D.
REQ-035 The bench SHALL cover: MAKE_BYTES_HEADER_EN defined, i_word=32'h01020304 -> byte sequence A5, 01, 02, 03, 04, then o_done.

Source files
------------

// File: rtl/make_bytes.sv
// Serialises a 32-bit word into UART bytes with a start/done handshake per byte.
// Optional leading header byte 8'hA5 is built in when MAKE_BYTES_HEADER_EN is defined.
module make_bytes #(
    parameter int MSB_FIRST = 1,
    parameter int COUNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_word,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_word_count
);

`ifdef MAKE_BYTES_HEADER_EN
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
`else
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDX_W-1:0]   byte_idx_inc;
    logic [31:0]        word_q;
    logic [7:0]         tx_data;
    logic [COUNT_W-1:0] word_count;

    // Map a position in the outgoing byte stream to the byte that goes on the wire.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [IDX_W-1:0] idx);
        logic [1:0] pos;
`ifdef MAKE_BYTES_HEADER_EN
        logic [IDX_W-1:0] data_idx;
        data_idx = idx - IDX_W'(1);
        pos      = data_idx[1:0];
`else
        pos      = idx;
`endif
        if (MSB_FIRST != 0) begin
            pos = 2'd3 - pos;
        end
        case (pos)
            2'd0:    pick_byte = w[7:0];
            2'd1:    pick_byte = w[15:8];
            2'd2:    pick_byte = w[23:16];
            default: pick_byte = w[31:24];
        endcase
`ifdef MAKE_BYTES_HEADER_EN
        if (idx == '0) begin
            pick_byte = HEADER_BYTE;
        end
`endif
    endfunction

    assign byte_idx_inc = byte_idx + IDX_W'(1);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    state_next = (byte_idx == LAST_IDX) ? ST_FINISH : ST_SEND;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            word_q     <= '0;
            tx_data    <= 8'h00;
            word_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        word_q   <= i_word;
                        byte_idx <= '0;
                        tx_data  <= pick_byte(i_word, '0);
                    end
                end
                ST_WAIT: begin
                    // The next byte is loaded on the same edge that sees done, so it is
                    // already on o_tx_data when the following start pulse appears.
                    if (i_tx_done) begin
                        byte_idx <= byte_idx_inc;
                        if (byte_idx != LAST_IDX) begin
                            tx_data <= pick_byte(word_q, byte_idx_inc);
                        end
                    end
                end
                ST_FINISH: begin
                    word_count <= word_count + COUNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready      = (state == ST_IDLE);
    assign o_tx_start   = (state == ST_SEND);
    assign o_done       = (state == ST_FINISH);
    assign o_tx_data    = tx_data;
    assign o_word_count = word_count;

endmodule
